// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package regfile_pkg;

   localparam int unsigned XLEN_DEF = 32;
   localparam int unsigned NREG_DEF = 32;
   localparam int unsigned NRP_DEF  = 2;
   localparam int unsigned NWP_DEF  = 2;
   localparam int unsigned X0       = 0;

   // Address width for a power-of-two register count (at least 1 bit).
   function automatic int unsigned aw_of(input int unsigned n);
      int unsigned w;
      w = 1;
      for (int unsigned i = 1; i < 32; i++)
         if ((64'd1 << i) < 64'(n)) w = i + 1;
      return w;
   endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-producer scoreboard: one bit per register, set on issue,
// cleared on write, wiped by flush.
module rf_scoreboard
   import regfile_pkg::*;
#(
   parameter  int unsigned NREG = NREG_DEF,
   parameter  int unsigned NWP  = NWP_DEF,
   localparam int unsigned AW   = aw_of(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NWP-1:0]    wr_en,
   input  logic [NWP*AW-1:0] wr_addr,
   input  logic              iss_en,
   input  logic [AW-1:0]     iss_addr,
   input  logic              flush,
   output logic [NREG-1:0]   pend
);

   logic [NREG-1:0] clr;
   logic [NREG-1:0] set;
   logic [NREG-1:0] pend_d;

   // Set is applied after clear so a coincident issue keeps the new producer.
   always_comb begin
      clr = '0;
      for (int unsigned j = 0; j < NWP; j++)
         if (wr_en[j]) clr[wr_addr[j*AW +: AW]] = 1'b1;
      set = '0;
      if (iss_en) set[iss_addr] = 1'b1;
      set[X0] = 1'b0;
      pend_d = flush ? '0 : ((pend & ~clr) | set);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pend <= '0;
      else     pend <= pend_d;
   end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with zero-latency write bypass, pending-producer
// scoreboard and committed-write counter.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter  int unsigned XLEN = XLEN_DEF,
   parameter  int unsigned NREG = NREG_DEF,
   parameter  int unsigned NRP  = NRP_DEF,
   parameter  int unsigned NWP  = NWP_DEF,
   localparam int unsigned AW   = aw_of(NREG)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRP*AW-1:0]   rd_addr,
   output logic [NRP*XLEN-1:0] rd_data,
   output logic [NRP-1:0]      rd_busy,
   input  logic [NWP-1:0]      wr_en,
   input  logic [NWP*AW-1:0]   wr_addr,
   input  logic [NWP*XLEN-1:0] wr_data,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_addr,
   input  logic                flush,
   input  logic [AW-1:0]       dbg_addr,
   output logic [XLEN-1:0]     dbg_data,
   output logic [31:0]         wr_count
);

   logic [XLEN-1:0] mem  [NREG];
   logic [XLEN-1:0] wdat [NREG];
   logic [NREG-1:0] hit;
   logic [NREG-1:0] pend;
   logic [31:0]     nhit;
   logic [31:0]     cnt_q;
   logic [AW-1:0]   ra;

   // Per-register winning write; ascending port order lets the highest
   // index overwrite. Writes are masked while reset is held.
   always_comb begin
      hit = '0;
      for (int unsigned r = 0; r < NREG; r++) wdat[r] = '0;
      for (int unsigned j = 0; j < NWP; j++) begin
         if (wr_en[j] && !rst) begin
            hit[wr_addr[j*AW +: AW]]  = 1'b1;
            wdat[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
         end
      end
      hit[X0] = 1'b0;
      nhit    = 32'($countones(hit));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned r = 0; r < NREG; r++) mem[r] <= '0;
         cnt_q <= '0;
      end else begin
         for (int unsigned r = 0; r < NREG; r++)
            if (hit[r]) mem[r] <= wdat[r];
         cnt_q <= cnt_q + nhit;
      end
   end

   rf_scoreboard #(
      .NREG (NREG),
      .NWP  (NWP)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .flush    (flush),
      .pend     (pend)
   );

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      ra      = '0;
      for (int unsigned k = 0; k < NRP; k++) begin
         ra = rd_addr[k*AW +: AW];
         if (!rst) begin
            rd_data[k*XLEN +: XLEN] = hit[ra] ? wdat[ra] : mem[ra];
            rd_busy[k]              = pend[ra] && !hit[ra];
         end
      end
   end

   assign dbg_data = mem[dbg_addr];
   assign wr_count = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard-driven bench for regfile_sb: directed scenarios then a
// randomized phase checked against a behavioural model.
module tb_regfile_sb;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int NRP  = 2;
   localparam int NWP  = 2;
   localparam int AW   = 5;

   logic                clk = 1'b0;
   logic                rst;
   logic [NRP*AW-1:0]   rd_addr;
   logic [NRP*XLEN-1:0] rd_data;
   logic [NRP-1:0]      rd_busy;
   logic [NWP-1:0]      wr_en;
   logic [NWP*AW-1:0]   wr_addr;
   logic [NWP*XLEN-1:0] wr_data;
   logic                iss_en;
   logic [AW-1:0]       iss_addr;
   logic                flush;
   logic [AW-1:0]       dbg_addr;
   logic [XLEN-1:0]     dbg_data;
   logic [31:0]         wr_count;

   always #5 clk = ~clk;

   regfile_sb #(
      .XLEN (XLEN),
      .NREG (NREG),
      .NRP  (NRP),
      .NWP  (NWP)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_busy  (rd_busy),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .flush    (flush),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data),
      .wr_count (wr_count)
   );

   typedef struct {
      int          kind;   // 0 rd_data, 1 rd_busy, 2 dbg_data, 3 wr_count
      int          port;
      logic [31:0] val;
      string       tag;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   logic [31:0] m_mem [NREG];
   bit          m_p   [NREG];
   logic [31:0] m_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic push(input int kind, input int port, input logic [31:0] val, input string tag);
      exp_t e;
      e.kind = kind; e.port = port; e.val = val; e.tag = tag;
      q.push_back(e);
   endtask

   task automatic drain();
      exp_t        e;
      logic [31:0] got;
      while (q.size() > 0) begin
         e = q.pop_front();
         case (e.kind)
            0:       got = rd_data[e.port*XLEN +: XLEN];
            1:       got = {31'b0, rd_busy[e.port]};
            2:       got = dbg_data;
            default: got = wr_count;
         endcase
         check(e.tag, got, e.val);
      end
   endtask

   task automatic idle();
      rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
      iss_en = 1'b0; iss_addr = '0; flush = 1'b0; dbg_addr = '0;
   endtask

   task automatic wr(input int p, input int a, input logic [31:0] d);
      wr_en[p] = 1'b1;
      wr_addr[p*AW +: AW] = AW'(a);
      wr_data[p*XLEN +: XLEN] = d;
   endtask

   task automatic rd(input int k, input int a);
      rd_addr[k*AW +: AW] = AW'(a);
   endtask

   task automatic iss(input int a);
      iss_en = 1'b1;
      iss_addr = AW'(a);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // Reset holds everything at zero and ignores writes/issue.
      rst = 1'b1; idle();
      wr(0, 5, 32'h1); iss(5); rd(0, 5); dbg_addr = 5;
      #1;
      push(0, 0, 32'h0, "rst_rd"); push(1, 0, 32'h0, "rst_busy");
      push(2, 0, 32'h0, "rst_dbg"); push(3, 0, 32'h0, "rst_cnt");
      drain();
      tick();
      push(3, 0, 32'h0, "rst_cnt_edge"); push(0, 0, 32'h0, "rst_rd_edge");
      drain();
      rst = 1'b0; idle();

      // Same-cycle bypass vs. no-bypass debug port.
      wr(0, 5, 32'h55); tick(); idle();
      wr(0, 5, 32'hDEADBEEF); rd(0, 5); dbg_addr = 5; #1;
      push(0, 0, 32'hDEADBEEF, "byp_x5"); push(2, 0, 32'h55, "dbg_old_x5");
      drain();
      tick(); idle(); dbg_addr = 5; #1;
      push(2, 0, 32'hDEADBEEF, "dbg_new_x5"); push(3, 0, 32'd2, "cnt_x5");
      drain();

      // Two ports to one register: highest port wins, counted once.
      wr(0, 7, 32'h11); wr(1, 7, 32'h22); rd(1, 7); #1;
      push(0, 1, 32'h22, "byp_x7");
      drain();
      tick(); idle(); dbg_addr = 7; #1;
      push(2, 0, 32'h22, "x7_hi_port"); push(3, 0, 32'd3, "cnt_x7");
      drain();

      // x0 is hardwired.
      wr(0, 0, 32'hFFFFFFFF); rd(0, 0); iss(0); #1;
      push(0, 0, 32'h0, "x0_byp"); push(1, 0, 32'h0, "x0_busy_wr");
      drain();
      tick(); idle(); rd(0, 0); #1;
      push(0, 0, 32'h0, "x0_rd"); push(1, 0, 32'h0, "x0_busy");
      push(3, 0, 32'd3, "cnt_x0");
      drain();

      // Pending set / bypassed clear / issue-beats-write.
      iss(3); tick(); idle(); rd(0, 3); #1;
      push(1, 0, 32'h1, "x3_busy");
      drain();
      wr(1, 3, 32'h5); #1;
      push(1, 0, 32'h0, "x3_clr_byp"); push(0, 0, 32'h5, "x3_data");
      drain();
      tick(); idle(); rd(0, 3); #1;
      push(1, 0, 32'h0, "x3_clr"); push(3, 0, 32'd4, "cnt_x3");
      drain();
      iss(3); wr(0, 3, 32'h6); tick(); idle(); rd(0, 3); #1;
      push(1, 0, 32'h1, "x3_newprod"); push(0, 0, 32'h6, "x3_data6");
      push(3, 0, 32'd5, "cnt_x3b");
      drain();
      wr(0, 3, 32'h6); rd(0, 3); #1;
      push(1, 0, 32'h0, "x3_sameval_byp");
      drain();
      tick(); idle(); rd(0, 3); #1;
      push(1, 0, 32'h0, "x3_sameval"); push(3, 0, 32'd6, "cnt_sameval");
      drain();

      // Flush overrides a coincident issue.
      idle(); iss(1); tick();
      idle(); iss(2); tick();
      idle(); iss(4); tick();
      idle(); rd(0, 1); rd(1, 2); #1;
      push(1, 0, 32'h1, "x1_busy"); push(1, 1, 32'h1, "x2_busy");
      drain();
      flush = 1'b1; iss(9); tick(); idle();
      rd(0, 1); rd(1, 2); #1;
      push(1, 0, 32'h0, "flush_x1"); push(1, 1, 32'h0, "flush_x2");
      drain();
      rd(0, 4); rd(1, 9); #1;
      push(1, 0, 32'h0, "flush_x4"); push(1, 1, 32'h0, "flush_x9");
      drain();

      // Asynchronous reset mid-cycle, then counter wrap.
      idle(); wr(0, 10, 32'h1234); tick(); idle(); dbg_addr = 10; #1;
      push(2, 0, 32'h1234, "x10_written"); push(3, 0, 32'd7, "cnt_x10");
      drain();
      @(posedge clk); #3; rst = 1'b1; #1;
      push(2, 0, 32'h0, "rst_async_x10"); push(3, 0, 32'h0, "rst_async_cnt");
      drain();
      @(negedge clk); wr(0, 11, 32'h77); tick(); idle();
      rst = 1'b0; dbg_addr = 11; #1;
      push(3, 0, 32'h0, "rst_wr_ignored_cnt"); push(2, 0, 32'h0, "rst_wr_ignored_x11");
      drain();
      @(negedge clk);
      force dut.cnt_q = 32'hFFFFFFFF;
      #1;
      release dut.cnt_q;
      wr(0, 12, 32'h1); wr(1, 13, 32'h2); tick(); idle(); #1;
      push(3, 0, 32'h1, "cnt_wrap");
      drain();

      // Randomized phase against a behavioural model.
      @(negedge clk); rst = 1'b1; #1; rst = 1'b0;
      for (int r = 0; r < NREG; r++) begin m_mem[r] = '0; m_p[r] = 1'b0; end
      m_cnt = '0;
      for (int c = 0; c < 80; c++) begin
         bit          hv [8];
         logic [31:0] hd [8];
         int          a;
         idle();
         for (int j = 0; j < NWP; j++)
            if ($urandom_range(0, 1) == 1) wr(j, $urandom_range(0, 7), $urandom);
         if ($urandom_range(0, 2) == 0) iss($urandom_range(0, 7));
         flush = ($urandom_range(0, 9) == 0);
         for (int k = 0; k < NRP; k++) rd(k, $urandom_range(0, 7));
         dbg_addr = AW'($urandom_range(0, 7));
         #1;
         for (int r = 0; r < 8; r++) begin hv[r] = 1'b0; hd[r] = '0; end
         for (int j = 0; j < NWP; j++) begin
            a = int'(wr_addr[j*AW +: AW]);
            if (wr_en[j] && a != 0) begin hv[a] = 1'b1; hd[a] = wr_data[j*XLEN +: XLEN]; end
         end
         for (int k = 0; k < NRP; k++) begin
            a = int'(rd_addr[k*AW +: AW]);
            push(0, k, hv[a] ? hd[a] : m_mem[a], "rnd_rd");
            push(1, k, {31'b0, m_p[a] && !hv[a]}, "rnd_busy");
         end
         push(2, 0, m_mem[int'(dbg_addr)], "rnd_dbg");
         drain();
         @(posedge clk);
         for (int r = 1; r < 8; r++) begin
            if (hv[r]) begin m_mem[r] = hd[r]; m_cnt = m_cnt + 1; m_p[r] = 1'b0; end
         end
         if (iss_en && iss_addr != 0) m_p[int'(iss_addr)] = 1'b1;
         if (flush) for (int r = 0; r < NREG; r++) m_p[r] = 1'b0;
         @(negedge clk);
         push(3, 0, m_cnt, "rnd_cnt");
         drain();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
